// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadowed hex word, PWM brightness, blanking, frame pulse.
// Build option: define SEVSEG_LZB_EN for leading-zero blanking of the upper digits.
module sevseg_scan_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 10000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    clk_pi,
   input  logic                    rst_pi,
   input  logic [4*NUM_DIGITS-1:0] data_pi,
   input  logic [NUM_DIGITS-1:0]   dp_pi,
   input  logic                    load_pi,
   input  logic                    blank_pi,
   input  logic [3:0]              bright_pi,
   output logic [NUM_DIGITS-1:0]   en_po,
   output logic [6:0]              seg_po,
   output logic                    dp_po,
   output logic                    frame_po
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int STEP  = REFRESH_DIV / 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic             INV      = (SEG_ACTIVE_LOW != 0);

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] data_q;
   logic [NUM_DIGITS-1:0]   dp_q;

   logic                    cnt_wrap;
   logic [CNT_W-1:0]        phase_full;
   logic [3:0]              phase;
   logic [3:0]              nibble;
   logic [NUM_DIGITS-1:0]   onehot;
   logic                    hide;
   logic                    lit;

   function automatic logic [6:0] decode(input logic [3:0] hex);
      logic [6:0] s;
      case (hex)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

`ifdef SEVSEG_LZB_EN
   logic [NUM_DIGITS-1:0] suppress;

   // Walk down from the top digit; a digit is hidden while everything from it upward is zero.
   always_comb begin
      logic all_zero;
      suppress = '0;
      all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero    = all_zero && (data_q[4*k +: 4] == 4'h0);
         suppress[k] = all_zero && !dp_q[k];
      end
   end

   assign hide = suppress[idx];
`else
   assign hide = 1'b0;
`endif

   always_comb begin
      cnt_wrap   = (cnt == CNT_LAST);
      phase_full = cnt / CNT_W'(STEP);
      phase      = phase_full[3:0];
      nibble     = data_q[4*idx +: 4];
      onehot     = NUM_DIGITS'(1) << idx;
      lit        = (phase <= bright_pi) && !blank_pi && !hide;
   end

   // load_pi is a plain strobe: every cycle it is high the shadow copy is overwritten; no ready.
   always_ff @(posedge clk_pi) begin
      if (rst_pi) begin
         cnt      <= '0;
         idx      <= '0;
         data_q   <= '0;
         dp_q     <= '0;
         frame_po <= 1'b0;
         en_po    <= {NUM_DIGITS{INV}};
         seg_po   <= {7{INV}};
         dp_po    <= INV;
      end else begin
         cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
         if (cnt_wrap) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
         frame_po <= cnt_wrap && (idx == IDX_LAST);
         if (load_pi) begin
            data_q <= data_pi;
            dp_q   <= dp_pi;
         end
         en_po  <= (lit ? onehot : '0) ^ {NUM_DIGITS{INV}};
         seg_po <= (lit ? decode(nibble) : 7'h00) ^ {7{INV}};
         dp_po  <= (lit && dp_q[idx]) ^ INV;
      end
   end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Bench for sevseg_scan_ctrl: elapsed-cycle reference model checked every cycle, plus directed literal checks.
// Honours SEVSEG_LZB_EN the same way the design does.
module tb_sevseg_scan_ctrl;

   localparam int ND    = 4;
   localparam int RD    = 32;
   localparam int FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        rst_pi = 1'b1;
   logic [15:0] data_pi = '0;
   logic [3:0]  dp_pi = '0;
   logic        load_pi = 1'b0;
   logic        blank_pi = 1'b0;
   logic [3:0]  bright_pi = 4'd15;
   logic [3:0]  en_po;
   logic [6:0]  seg_po;
   logic        dp_po;
   logic        frame_po;

   int checks = 0;
   int errors = 0;
   int e = 0;

   sevseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1)) dut (
      .clk_pi(clk), .rst_pi(rst_pi), .data_pi(data_pi), .dp_pi(dp_pi), .load_pi(load_pi),
      .blank_pi(blank_pi), .bright_pi(bright_pi), .en_po(en_po), .seg_po(seg_po),
      .dp_po(dp_po), .frame_po(frame_po)
   );

   // clock/reset block
   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: everything follows from the number of edges since reset.
   int          n = 0;
   logic [15:0] m_data = '0;
   logic [3:0]  m_dp = '0;
   logic        model_valid = 1'b0;
   logic [3:0]  exp_en;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic        exp_frame;

   always @(posedge clk) begin : model
      int   slot_pos, digit, phase;
      logic sup, lit;
      if (rst_pi) begin
         n = 0; m_data = '0; m_dp = '0;
         exp_en = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_frame = 1'b0;
         model_valid = 1'b1;
      end else begin
         slot_pos = n % RD;
         digit    = (n / RD) % ND;
         phase    = slot_pos / (RD / 16);
`ifdef SEVSEG_LZB_EN
         sup = (digit > 0) && ((m_data >> (4 * digit)) == 16'h0) && !m_dp[digit];
`else
         sup = 1'b0;
`endif
         lit       = (phase <= int'(bright_pi)) && !blank_pi && !sup;
         exp_en    = lit ? ~(4'(1) << digit) : 4'hF;
         exp_seg   = lit ? ~seg_tab[m_data[4*digit +: 4]] : 7'h7F;
         exp_dp    = lit ? ~m_dp[digit] : 1'b1;
         exp_frame = (n % FRAME) == FRAME - 1;
         n++;
         if (load_pi) begin
            m_data = data_pi;
            m_dp   = dp_pi;
         end
      end
   end

   // scoreboard compare, every cycle once the model is anchored by a reset
   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_en", 32'(en_po), 32'(exp_en));
         chk("model_seg", 32'(seg_po), 32'(exp_seg));
         chk("model_dp", 32'(dp_po), 32'(exp_dp));
         chk("model_frame", 32'(frame_po), 32'(exp_frame));
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic tick_to(input int target);
      while (e < target) tick();
   endtask

   task automatic do_reset();
      rst_pi = 1'b1;
      repeat (3) tick();
      chk("rst_en", 32'(en_po), 32'hF);
      chk("rst_seg", 32'(seg_po), 32'h7F);
      chk("rst_dp", 32'(dp_po), 32'h1);
      chk("rst_frame", 32'(frame_po), 32'h0);
      rst_pi = 1'b0;
      e = 0;
   endtask

   task automatic pin(input string name, input logic [3:0] en, input logic [6:0] seg, input logic dp);
      chk({name, "_en"}, 32'(en_po), 32'(en));
      chk({name, "_seg"}, 32'(seg_po), 32'(seg));
      chk({name, "_dp"}, 32'(dp_po), 32'(dp));
   endtask

   initial begin
      int cnt_on, cnt_fr, frame_at;

      // reset and scan/decode
      do_reset();
      data_pi = 16'h1F80; dp_pi = 4'b0100; load_pi = 1'b1;
      tick();
      load_pi = 1'b0;
      pin("first_digit0", 4'hE, 7'h40, 1'b1);
      tick_to(16);  pin("scan_d0", 4'hE, 7'h40, 1'b1);
      tick_to(48);  pin("scan_d1", 4'hD, 7'h00, 1'b1);
      tick_to(80);  pin("scan_d2", 4'hB, 7'h0E, 1'b0);
      tick_to(112); pin("scan_d3", 4'h7, 7'h79, 1'b1);
      tick_to(127); chk("frame_before", 32'(frame_po), 32'h0);
      tick();       chk("frame_at_128", 32'(frame_po), 32'h1);
      cnt_fr = 0;
      while (e < 256) begin
         tick();
         if (frame_po) cnt_fr++;
      end
      chk("frame_count", 32'(cnt_fr), 32'd1);
      chk("frame_at_256", 32'(frame_po), 32'h1);

      // brightness
      bright_pi = 4'd3;
      cnt_on = 0;
      repeat (RD) begin tick(); if (en_po != 4'hF) cnt_on++; end
      chk("bright3_on", 32'(cnt_on), 32'd8);
      bright_pi = 4'd0;
      cnt_on = 0;
      repeat (RD) begin tick(); if (en_po != 4'hF) cnt_on++; end
      chk("bright0_on", 32'(cnt_on), 32'd2);

      // blanking keeps the scan running
      bright_pi = 4'd15; blank_pi = 1'b1;
      cnt_on = 0; cnt_fr = 0;
      repeat (FRAME) begin
         tick();
         if (en_po != 4'hF) cnt_on++;
         if (frame_po) cnt_fr++;
      end
      chk("blank_on", 32'(cnt_on), 32'd0);
      chk("blank_frames", 32'(cnt_fr), 32'd1);
      blank_pi = 1'b0;

      // mid-slot load at cnt=10 of slot 0
      do_reset();
      data_pi = 16'h0005; dp_pi = 4'b0000;
      tick_to(10);
      load_pi = 1'b1;
      tick();
      load_pi = 1'b0;
      chk("midload_old", 32'(seg_po), 32'h40);
      tick();
      pin("midload_new", 4'hE, 7'h12, 1'b1);

      // leading zeros
      do_reset();
      data_pi = 16'h0050; dp_pi = 4'b0000; load_pi = 1'b1;
      tick();
      load_pi = 1'b0;
      tick_to(16);  pin("lz_d0", 4'hE, 7'h40, 1'b1);
      tick_to(48);  pin("lz_d1", 4'hD, 7'h12, 1'b1);
`ifdef SEVSEG_LZB_EN
      tick_to(80);  pin("lz_d2", 4'hF, 7'h7F, 1'b1);
      tick_to(112); pin("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
      tick_to(80);  pin("lz_d2", 4'hB, 7'h40, 1'b1);
      tick_to(112); pin("lz_d3", 4'h7, 7'h40, 1'b1);
`endif
      dp_pi = 4'b1000; load_pi = 1'b1;
      tick();
      load_pi = 1'b0;
`ifdef SEVSEG_LZB_EN
      tick_to(208); pin("lzdp_d2", 4'hF, 7'h7F, 1'b1);
`else
      tick_to(208); pin("lzdp_d2", 4'hB, 7'h40, 1'b1);
`endif
      tick_to(240); pin("lzdp_d3", 4'h7, 7'h40, 1'b0);

      // reset in the middle of slot 2
      data_pi = 16'hFFFF; load_pi = 1'b1;
      tick();
      load_pi = 1'b0;
      tick_to(336);
      rst_pi = 1'b1;
      tick();
      pin("midrst", 4'hF, 7'h7F, 1'b1);
      chk("midrst_frame", 32'(frame_po), 32'h0);
      rst_pi = 1'b0;
      e = 0;
      tick();
      pin("midrst_restart", 4'hE, 7'h40, 1'b1);
      frame_at = -1;
      while (e < 200 && frame_at < 0) begin
         tick();
         if (frame_po) frame_at = e;
      end
      chk("midrst_first_frame", 32'(frame_at), 32'd128);

      // randomized traffic, model checks every cycle
      for (int i = 0; i < 3000; i++) begin
         rst_pi    = ($urandom_range(0, 199) == 0);
         load_pi   = ($urandom_range(0, 7) == 0);
         data_pi   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         dp_pi     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         bright_pi = 4'($urandom_range(0, 15));
         blank_pi  = ($urandom_range(0, 9) == 0);
         tick();
      end
      rst_pi = 1'b0; load_pi = 1'b0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sevseg_scan_ctrl.md
# sevseg_scan_ctrl

Parametrised multiplexed seven-segment display controller, the successor of the fixed 4-digit hex decoder used by the peripheral test tops. It captures a hex word on a load strobe and scans it across NUM_DIGITS common-anode digits. Per-digit decimal points, global blanking, 16-step PWM brightness and a frame-done pulse are included. It sits between the register/peripheral bus and the board's en/seg pins, on the same clock as the CPU peripherals.

## Interface
- NUM_DIGITS, 4: digits driven, 1..8.
- REFRESH_DIV, 10000: clock cycles per digit slot; must be a multiple of 16, minimum 16.
- SEG_ACTIVE_LOW, 1: 1 = en/seg/dp outputs active-low (Basys3), 0 = active-high.

- clk_pi  in  1  system clock; all logic on rising edge.
- rst_pi  in  1  synchronous, active-high reset.
- data_pi  in  4*NUM_DIGITS  hex word; nibble k drives digit k (digit 0 = rightmost).
- dp_pi  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- load_pi  in  1  capture data_pi/dp_pi into shadow registers when high.
- blank_pi  in  1  1 = all digits off (scan continues).
- bright_pi  in  4  duty: digit lit for (bright_pi+1)/16 of its slot.
- en_po  out  NUM_DIGITS  digit enables, one-hot when lit.
- seg_po  out  7  segments, bit0=a … bit6=g.
- dp_po  out  1  decimal point of active digit.
- frame_po  out  1  one-cycle pulse at end of each full scan.

## Operation
- Shadow registers data_q (4*NUM_DIGITS), dp_q (NUM_DIGITS); written on any cycle with load_pi=1, else hold. Reset value 0.
- Prescaler cnt: 0..REFRESH_DIV-1, increments every cycle, wraps to 0.
- Digit index idx: 0..NUM_DIGITS-1; advances when cnt wraps; idx wraps NUM_DIGITS-1 → 0, and on that same edge frame_po=1 for exactly one cycle.
- PWM phase = cnt / (REFRESH_DIV/16), range 0..15. Digit lit iff phase <= bright_pi and blank_pi=0 and (see Configuration) not suppressed.
- Decode (active-high form): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. SEG_ACTIVE_LOW=1 inverts seg_po, dp_po and en_po.
- When digit not lit: en_po all inactive, seg_po all inactive, dp_po inactive (no ghosting).
- When lit: en_po has only bit idx active; seg_po = decode(data_q[4*idx+:4]); dp_po = dp_q[idx].
- No state machine beyond cnt/idx; operation is free-running from reset.

## Timing
- Reset (rst_pi=1 on an edge): cnt=0, idx=0, data_q=0, dp_q=0, frame_po=0; en_po, seg_po, dp_po all inactive (all ones when SEG_ACTIVE_LOW=1).
- en_po/seg_po/dp_po are registered: they reflect cnt/idx/data_q/bright_pi/blank_pi of the previous cycle (1-cycle latency).
- load_pi at edge N: data_q valid after N; outputs show new value after edge N+1, even mid-slot.
- load_pi coincident with idx advance: new digit shows newly loaded data (shadow write and index advance take effect together; output stage uses both on the next edge).
- bright_pi/blank_pi changes take effect on the next output update; no slot realignment.
- rst_pi mid-scan: full reset as above; scan restarts at digit 0, cnt 0.
- frame_po asserts on the edge where idx goes NUM_DIGITS-1 → 0; period = NUM_DIGITS*REFRESH_DIV cycles.
- NUM_DIGITS=1: idx stays 0, frame_po pulses every REFRESH_DIV cycles.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking. Digit k>0 is suppressed (treated as not lit) when data_q nibbles k..NUM_DIGITS-1 are all zero; digit 0 always displayed. A digit with dp_q[k]=1 is never suppressed.
- SEVSEG_LZB_EN undefined: all digits displayed, zeros included; no suppression logic synthesised.

## Test plan
- Reset: NUM_DIGITS=4, REFRESH_DIV=32, SEG_ACTIVE_LOW=1; hold rst_pi 3 cycles → en_po=4'hF, seg_po=7'h7F, dp_po=1, frame_po=0; after release digit 0 shows seg_po=7'h40 ("0"), en_po=4'hE.
- Scan/decode: load 16'h1F80, dp_pi=4'b0100, bright 15 → slot sequence en_po E,D,B,7 with seg_po 40 ("0"), 00 ("8"), 0E ("F") + dp_po=0, 79 ("1"); frame_po single pulse every 128 cycles.
- Brightness: bright_pi=3 → en_po active for exactly 8 cycles of each 32-cycle slot (phases 0..3), inactive remaining 24; bright_pi=0 → 2 cycles.
- Blank and mid-slot load: blank_pi=1 → en_po=4'hF continuously, frame_po still pulses; load 16'h0005 at cnt=10 of slot 0 → seg_po changes to 12 ("5") two edges later, same slot.
- Leading-zero (SEVSEG_LZB_EN defined): load 16'h0050 → digits 2,3 dark for whole slot, digit 1 shows "5", digit 0 shows "0"; with dp_pi=4'b1000 digit 3 lit showing "0"+dp. Undefined: all four digits lit.
- Reset mid-operation: assert rst_pi during slot 2 → next cycle outputs inactive, data_q=0; after release scan restarts at digit 0 and first frame_po arrives 128 cycles later.
